mem_port_arbiter: RTL and testbench

- Shares a single data-memory port among CORE_COUNT cores. Each core's LD/ST port (enable, addr, wr_data, rd_data, ready_sig) connects here.
- Grants one outstanding access at a time, round-robin by default, and forwards it to the memory.
- Returns read data and a one-cycle ready_sig pulse to the granted core only; every other core stays stalled in M until it is served.
- Sits between the core array and the shared memory / memory-mapped interconnect.

---
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one data-memory port among CORE_COUNT core LD/ST ports.
//               One access is outstanding at a time. Read data is broadcast,
//               and a one-cycle ready pulse goes to the granted core only.
//               Optional macro MEM_ARB_FIXED_PRIO_EN selects fixed priority
//               (lowest index wins). Without it, arbitration is round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int CORE_COUNT = 4,
  parameter int REG_SIZE   = 8,
  parameter int ADDR_SIZE  = 12,
  localparam int GW = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [2*CORE_COUNT-1:0]         core_enable,
  input  logic [ADDR_SIZE*CORE_COUNT-1:0] core_addr,
  input  logic [REG_SIZE*CORE_COUNT-1:0]  core_wr_data,
  output logic [REG_SIZE-1:0]             core_rd_data,
  output logic [CORE_COUNT-1:0]           core_ready_sig,
  output logic [1:0]                      mem_enable,
  output logic [ADDR_SIZE-1:0]            mem_addr,
  output logic [REG_SIZE-1:0]             mem_wr_data,
  input  logic [REG_SIZE-1:0]             mem_rd_data,
  input  logic                            mem_ready,
  output logic                            busy,
  output logic [GW-1:0]                   grant_id
);

  localparam logic [1:0] C_OP_LD = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [GW-1:0]         r_grant;
  logic [1:0]            r_op;
  logic [ADDR_SIZE-1:0]  r_addr;
  logic [REG_SIZE-1:0]   r_wdata;
  logic [REG_SIZE-1:0]   r_rdata;
  logic                  r_busy;

  logic [CORE_COUNT-1:0] w_valid;
  logic                  w_found;
  logic [GW-1:0]         w_winner;
  logic [1:0]            w_sel_op;
  logic [ADDR_SIZE-1:0]  w_sel_addr;
  logic [REG_SIZE-1:0]   w_sel_wdata;

  // A request is valid only for LD (01) or ST (10); 11 is never granted.
  for (genvar i = 0; i < CORE_COUNT; i++) begin : g_valid
    assign w_valid[i] = core_enable[2*i+1] ^ core_enable[2*i];
  end

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Fixed priority: scan downward so the lowest valid index is the last to win.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = CORE_COUNT - 1; i >= 0; i--) begin
      if (w_valid[i]) begin
        w_found  = 1'b1;
        w_winner = GW'(i);
      end
    end
  end
`else
  logic [GW-1:0] r_rr_ptr;
  logic [GW:0]   w_idx;

  // Round-robin: first valid index at or after r_rr_ptr, wrapping; the scan
  // runs from the farthest offset down so the nearest candidate wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = CORE_COUNT - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_rr_ptr} + (GW+1)'(k);
      if (w_idx >= (GW+1)'(CORE_COUNT)) w_idx = w_idx - (GW+1)'(CORE_COUNT);
      if (w_valid[w_idx[GW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[GW-1:0];
      end
    end
  end

  // Pointer moves past the served core when the access completes (entry to RESP).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (r_state == ST_WAIT && mem_ready) begin
      r_rr_ptr <= (r_grant == GW'(CORE_COUNT - 1)) ? '0 : r_grant + 1'b1;
    end
  end
`endif

  // Select the winner's op, address and store data for latching.
  always_comb begin
    w_sel_op    = 2'b00;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < CORE_COUNT; i++) begin
      if (w_winner == GW'(i)) begin
        w_sel_op    = core_enable[2*i +: 2];
        w_sel_addr  = core_addr[ADDR_SIZE*i +: ADDR_SIZE];
        w_sel_wdata = core_wr_data[REG_SIZE*i +: REG_SIZE];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic plus the two decoded outputs (memory op and ready pulse).
  always_comb begin
    w_next         = r_state;
    mem_enable     = 2'b00;
    core_ready_sig = '0;
    case (r_state)
      ST_IDLE: if (w_found) w_next = ST_WAIT;
      ST_WAIT: begin
        mem_enable = r_op;
        if (mem_ready) w_next = ST_RESP;
      end
      ST_RESP: begin
        core_ready_sig[r_grant] = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Transaction registers: latched in IDLE, never re-sampled until the next grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant <= '0;
      r_op    <= 2'b00;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_busy <= (w_next != ST_IDLE);
      if (r_state == ST_IDLE && w_found) begin
        r_grant <= w_winner;
        r_op    <= w_sel_op;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
      end
      if (r_state == ST_WAIT && mem_ready && r_op == C_OP_LD) begin
        r_rdata <= mem_rd_data;
      end
    end
  end

  assign core_rd_data = r_rdata;
  assign mem_addr     = r_addr;
  assign mem_wr_data  = r_wdata;
  assign busy         = r_busy;
  assign grant_id     = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter: directed scenarios
//               plus randomized traffic checked against a behavioural model.
//               Honours MEM_ARB_FIXED_PRIO_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
  localparam int N  = 4;
  localparam int RW = 8;
  localparam int AW = 12;
  localparam int P_IDLE = 0;
  localparam int P_WAIT = 1;
  localparam int P_RESP = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [2*N-1:0]    core_enable;
  logic [AW*N-1:0]   core_addr;
  logic [RW*N-1:0]   core_wr_data;
  logic [RW-1:0]     core_rd_data;
  logic [N-1:0]      core_ready_sig;
  logic [1:0]        mem_enable;
  logic [AW-1:0]     mem_addr;
  logic [RW-1:0]     mem_wr_data;
  logic [RW-1:0]     mem_rd_data;
  logic              mem_ready;
  logic              busy;
  logic [1:0]        grant_id;

  int n_cmp  = 0;
  int n_fail = 0;
  int cur_lat = 0;
  int wait_cnt = 0;
  bit ovr_en = 1'b0;
  logic [7:0] ovr_data = 8'h00;

  mem_port_arbiter #(.CORE_COUNT(N), .REG_SIZE(RW), .ADDR_SIZE(AW)) dut (
    .clk(clk), .reset(reset), .core_enable(core_enable), .core_addr(core_addr),
    .core_wr_data(core_wr_data), .core_rd_data(core_rd_data),
    .core_ready_sig(core_ready_sig), .mem_enable(mem_enable), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_ready(mem_ready),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Memory model: content is a fixed function of the address.
  function automatic logic [7:0] hash(input logic [11:0] a);
    return a[7:0] ^ {a[11:8], a[3:0]} ^ 8'h3C;
  endfunction

  // Memory answers after cur_lat extra cycles of a held request.
  always @(posedge clk) begin
    if (mem_enable != 2'b00 && !mem_ready) wait_cnt <= wait_cnt + 1;
    else                                   wait_cnt <= 0;
  end
  assign mem_ready   = (mem_enable != 2'b00) && (wait_cnt >= cur_lat);
  assign mem_rd_data = ovr_en ? ovr_data : hash(mem_addr);

  task automatic set_core(input int i, input logic [1:0] en, input logic [11:0] a, input logic [7:0] d);
    core_enable[2*i +: 2]    = en;
    core_addr[AW*i +: AW]    = a;
    core_wr_data[RW*i +: RW] = d;
  endtask

  function automatic bit is_valid(input int i);
    return core_enable[2*i +: 2] == 2'b01 || core_enable[2*i +: 2] == 2'b10;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    core_enable = '0; core_addr = '0; core_wr_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < N; i++) set_core(i, 2'b01, 12'(i * 16 + 3), 8'(i + 1));
    repeat (3) @(negedge clk);
    n_cmp += 7;
    if (busy !== 1'b0)          begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (mem_enable !== 2'b00)   begin n_fail++; $display("FAIL reset_mem_enable: got %b want 00", mem_enable); end
    if (mem_addr !== '0)        begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    if (mem_wr_data !== '0)     begin n_fail++; $display("FAIL reset_mem_wr_data: got %h want 0", mem_wr_data); end
    if (core_ready_sig !== '0)  begin n_fail++; $display("FAIL reset_ready: got %b want 0", core_ready_sig); end
    if (core_rd_data !== '0)    begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", core_rd_data); end
    if (grant_id !== '0)        begin n_fail++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
    core_enable = '0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_ld();
    cur_lat = 0; ovr_en = 1'b1; ovr_data = 8'hA7;
    set_core(2, 2'b01, 12'h305, 8'h00);
    @(negedge clk);
    n_cmp += 4;
    if (mem_enable !== 2'b01)  begin n_fail++; $display("FAIL ld_mem_enable: got %b want 01", mem_enable); end
    if (mem_addr !== 12'h305)  begin n_fail++; $display("FAIL ld_mem_addr: got %h want 305", mem_addr); end
    if (grant_id !== 2'd2)     begin n_fail++; $display("FAIL ld_grant: got %0d want 2", grant_id); end
    if (core_ready_sig !== '0) begin n_fail++; $display("FAIL ld_early_ready: got %b want 0000", core_ready_sig); end
    @(negedge clk);
    n_cmp += 3;
    if (core_ready_sig !== 4'b0100) begin n_fail++; $display("FAIL ld_ready: got %b want 0100", core_ready_sig); end
    if (core_rd_data !== 8'hA7)     begin n_fail++; $display("FAIL ld_rd_data: got %h want a7", core_rd_data); end
    if (mem_enable !== 2'b00)       begin n_fail++; $display("FAIL ld_resp_mem_enable: got %b want 00", mem_enable); end
    set_core(2, 2'b00, 12'h000, 8'h00);
    @(negedge clk);
    n_cmp += 3;
    if (core_ready_sig !== '0)  begin n_fail++; $display("FAIL ld_ready_after: got %b want 0000", core_ready_sig); end
    if (core_rd_data !== 8'hA7) begin n_fail++; $display("FAIL ld_rd_hold: got %h want a7", core_rd_data); end
    if (busy !== 1'b0)          begin n_fail++; $display("FAIL ld_busy_after: got %b want 0", busy); end
    ovr_en = 1'b0;
  endtask

  task automatic test_store_slow();
    logic [7:0] rd_before;
    int waits = 0, pulses = 0;
    rd_before = core_rd_data;
    cur_lat = 2;
    set_core(0, 2'b10, 12'h0AA, 8'h5C);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (mem_enable != 2'b00) begin
        waits++;
        n_cmp++;
        if (mem_wr_data !== 8'h5C || mem_enable !== 2'b10) begin
          n_fail++; $display("FAIL st_hold: got en=%b wd=%h want en=10 wd=5c", mem_enable, mem_wr_data);
        end
      end
      if (core_ready_sig != '0) begin
        pulses++;
        n_cmp++;
        if (core_ready_sig !== 4'b0001) begin n_fail++; $display("FAIL st_ready_target: got %b want 0001", core_ready_sig); end
        set_core(0, 2'b00, 12'h000, 8'h00);
      end
    end
    n_cmp += 3;
    if (waits != 3)                begin n_fail++; $display("FAIL st_wait_cycles: got %0d want 3", waits); end
    if (pulses != 1)               begin n_fail++; $display("FAIL st_pulses: got %0d want 1", pulses); end
    if (core_rd_data !== rd_before) begin n_fail++; $display("FAIL st_rd_unchanged: got %h want %h", core_rd_data, rd_before); end
    cur_lat = 0;
  endtask

  task automatic test_round_robin();
    int order[5];
    int got = 0;
    logic [1:0] prev_en = 2'b00;
    int exp;
    do_reset();
    cur_lat = 0;
    for (int i = 0; i < N; i++) set_core(i, 2'b01, 12'(12'h100 * i + i), 8'h00);
    for (int c = 0; c < 60 && got < 5; c++) begin
      @(negedge clk);
      if (prev_en == 2'b00 && mem_enable != 2'b00) begin
        order[got] = int'(grant_id);
        got++;
      end
      if (core_ready_sig != '0) begin
        n_cmp++;
        if (core_rd_data !== hash(12'(12'h100 * int'(grant_id) + int'(grant_id)))) begin
          n_fail++; $display("FAIL rr_rd_data: got %h want %h", core_rd_data, hash(12'(12'h100 * int'(grant_id) + int'(grant_id))));
        end
      end
      prev_en = mem_enable;
    end
    n_cmp++;
    if (got != 5) begin n_fail++; $display("FAIL rr_grant_count: got %0d want 5", got); end
    for (int k = 0; k < got; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp = 0;
`else
      exp = k % N;
`endif
      n_cmp++;
      if (order[k] != exp) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, order[k], exp); end
    end
    core_enable = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_illegal();
    int grants = 0;
    logic [1:0] prev_en = 2'b00;
    set_core(1, 2'b11, 12'h111, 8'h11);
    set_core(3, 2'b01, 12'h333, 8'h33);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (prev_en == 2'b00 && mem_enable != 2'b00) begin
        grants++;
        n_cmp++;
        if (grant_id !== 2'd3) begin n_fail++; $display("FAIL illegal_grant: got %0d want 3", grant_id); end
      end
      n_cmp++;
      if (core_ready_sig[1] !== 1'b0) begin n_fail++; $display("FAIL illegal_ready1: got %b want 0", core_ready_sig[1]); end
      prev_en = mem_enable;
    end
    n_cmp++;
    if (grants < 1) begin n_fail++; $display("FAIL illegal_no_grant: got %0d want >=1", grants); end
    core_enable = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    int seen = 0;
    cur_lat = 0;
    // Serve core 2 first so a stale pointer would favour core 3.
    set_core(2, 2'b01, 12'h222, 8'h00);
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge clk);
      if (core_ready_sig[2]) seen = 1;
    end
    set_core(2, 2'b00, 12'h000, 8'h00);
    n_cmp++;
    if (seen == 0) begin n_fail++; $display("FAIL rmw_setup_timeout: got no pulse want pulse on core 2"); end
    @(negedge clk);
    cur_lat = 1000;
    set_core(1, 2'b01, 12'h1F0, 8'h00);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (mem_enable !== 2'b01 || grant_id !== 2'd1) begin
      n_fail++; $display("FAIL rmw_in_wait: got en=%b gnt=%0d want en=01 gnt=1", mem_enable, grant_id);
    end
    reset = 1'b1;
    set_core(1, 2'b00, 12'h000, 8'h00);
    @(negedge clk);
    n_cmp += 3;
    if (mem_enable !== 2'b00)  begin n_fail++; $display("FAIL rmw_mem_enable: got %b want 00", mem_enable); end
    if (busy !== 1'b0)         begin n_fail++; $display("FAIL rmw_busy: got %b want 0", busy); end
    if (core_ready_sig !== '0) begin n_fail++; $display("FAIL rmw_ready: got %b want 0000", core_ready_sig); end
    reset = 1'b0;
    cur_lat = 0;
    @(negedge clk);
    n_cmp++;
    if (core_ready_sig !== '0) begin n_fail++; $display("FAIL rmw_ready_after: got %b want 0000", core_ready_sig); end
    set_core(0, 2'b01, 12'h0C0, 8'h00);
    set_core(3, 2'b01, 12'h3C0, 8'h00);
    @(negedge clk);
    n_cmp++;
    if (mem_enable !== 2'b01 || grant_id !== 2'd0) begin
      n_fail++; $display("FAIL rmw_fresh_grant: got en=%b gnt=%0d want en=01 gnt=0", mem_enable, grant_id);
    end
    core_enable = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic rand_req(input int i);
    int r;
    r = int'($urandom_range(0, 3));
    case (r)
      0: set_core(i, 2'b01, 12'($urandom), 8'($urandom));
      1: set_core(i, 2'b10, 12'($urandom), 8'($urandom));
      2: set_core(i, 2'b00, 12'h000, 8'h00);
      default: set_core(i, 2'b11, 12'($urandom), 8'($urandom));
    endcase
  endtask

  // Randomized traffic; the model picks winners from the requests it drove.
  task automatic test_random();
    int ph = P_IDLE, ptr = 0, gnt = 0, nxt, ntx = 0;
    logic [1:0] op = 2'b00;
    logic [11:0] ad = '0;
    logic [7:0] wd = '0, exp_rd = '0;
    bit prev_mr = 1'b0;
    logic [3:0] exp_ready;
    do_reset();
    cur_lat = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (ph == P_IDLE) begin
        nxt = -1;
        for (int k = N - 1; k >= 0; k--) if (is_valid((ptr + k) % N)) nxt = (ptr + k) % N;
        if (nxt >= 0) begin
          gnt = nxt; op = core_enable[2*gnt +: 2];
          ad = core_addr[AW*gnt +: AW]; wd = core_wr_data[RW*gnt +: RW];
          ph = P_WAIT;
        end
      end else if (ph == P_WAIT) begin
        if (prev_mr) begin
          ph = P_RESP; ntx++;
          if (op == 2'b01) exp_rd = hash(ad);
`ifdef MEM_ARB_FIXED_PRIO_EN
          ptr = 0;
`else
          ptr = (gnt + 1) % N;
`endif
        end
      end else begin
        ph = P_IDLE;
      end
      exp_ready = (ph == P_RESP) ? (4'b0001 << gnt) : 4'b0000;
      n_cmp += 4;
      if (busy !== (ph != P_IDLE)) begin n_fail++; $display("FAIL rnd_busy @%0d: got %b want %b", cyc, busy, ph != P_IDLE); end
      if (mem_enable !== ((ph == P_WAIT) ? op : 2'b00)) begin
        n_fail++; $display("FAIL rnd_mem_enable @%0d: got %b want %b", cyc, mem_enable, (ph == P_WAIT) ? op : 2'b00);
      end
      if (core_ready_sig !== exp_ready) begin n_fail++; $display("FAIL rnd_ready @%0d: got %b want %b", cyc, core_ready_sig, exp_ready); end
      if (core_rd_data !== exp_rd) begin n_fail++; $display("FAIL rnd_rd_data @%0d: got %h want %h", cyc, core_rd_data, exp_rd); end
      if (ph == P_WAIT) begin
        n_cmp++;
        if (grant_id !== 2'(gnt) || mem_addr !== ad || mem_wr_data !== wd) begin
          n_fail++; $display("FAIL rnd_access @%0d: got gnt=%0d a=%h d=%h want gnt=%0d a=%h d=%h",
                             cyc, grant_id, mem_addr, mem_wr_data, gnt, ad, wd);
        end
      end
      // New stimulus for the next edge.
      if (ph == P_RESP) rand_req(gnt);
      if (ph == P_WAIT && $urandom_range(0, 7) == 0) set_core(gnt, 2'b00, 12'h000, 8'h00);
      for (int i = 0; i < N; i++) if (!is_valid(i) && $urandom_range(0, 3) == 0) rand_req(i);
      if (ph != P_WAIT) cur_lat = int'($urandom_range(0, 3));
      prev_mr = mem_ready;
    end
    n_cmp++;
    if (ntx < 10) begin n_fail++; $display("FAIL rnd_throughput: got %0d transactions want >=10", ntx); end
    core_enable = '0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    core_enable = '0; core_addr = '0; core_wr_data = '0;
    test_reset();
    test_single_ld();
    test_store_slow();
    test_round_robin();
    test_illegal();
    test_reset_mid_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
